// File: rtl/fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Purpose  : Parametrised three-stage pipelined floating-point multiplier
//            with valid/ready handshake, opaque tag passthrough, NaN/Inf/zero
//            classification and overflow/underflow flags. Denormal inputs
//            are flushed to zero.
// Macro    : FMUL_PIPE_RNE_EN - when defined, results are rounded to nearest,
//            ties to even; when undefined, the mantissa is truncated.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  stage 1 can accept this cycle
//   x1, x2     in   operands {sign, exponent, mantissa}
//   in_tag     in   tag returned unchanged with the result
//   out_valid  out  result present
//   out_ready  in   consumer accepts result
//   y          out  product
//   out_tag    out  tag of this result
//   ovf        out  finite inputs overflowed to infinity
//   unf        out  nonzero finite inputs underflowed to zero
//   nan        out  result is the canonical quiet NaN
// ============================================================================
module fmul_pipe #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW+MW:0]      x1,
    input  logic [EW+MW:0]      x2,
    input  logic [TAGW-1:0]     in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EW+MW:0]      y,
    output logic [TAGW-1:0]     out_tag,
    output logic                ovf,
    output logic                unf,
    output logic                nan
);

    // Significand is split into a high half (HW bits, holds the hidden 1)
    // and a low half (LW bits). The product is approximated by
    // hi*hi*2^(2LW) + (hi*lo + lo*hi)*2^LW; the lo*lo term is dropped.
    localparam int SW   = MW + 1;
    localparam int LW   = SW / 2;
    localparam int HW   = SW - LW;
    localparam int PW   = 2 * SW;
    localparam int XW   = EW + 2;
    localparam int BIAS = (1 << (EW - 1)) - 1;

    // Without rounding the product bits below the result LSB are never
    // looked at, so they are not carried into stage 2.
`ifdef FMUL_PIPE_RNE_EN
    localparam int DROP = 0;
`else
    localparam int DROP = MW;
`endif

    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [EW+MW:0]       QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    // Whole pipeline advances together; bubbles hold while stalled too.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Stage valid bits
    // ------------------------------------------------------------------
    logic v1, v2;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: decode, classify, partial products
    // ------------------------------------------------------------------
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic [SW-1:0] sig_a, sig_b;
    logic [HW-1:0] hi_a, hi_b;
    logic [LW-1:0] lo_a, lo_b;
    logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign ea     = x1[MW +: EW];
    assign eb     = x2[MW +: EW];
    assign ma     = x1[MW-1:0];
    assign mb     = x2[MW-1:0];
    assign sig_a  = {1'b1, ma};
    assign sig_b  = {1'b1, mb};
    assign hi_a   = sig_a[SW-1 -: HW];
    assign hi_b   = sig_b[SW-1 -: HW];
    assign lo_a   = sig_a[LW-1:0];
    assign lo_b   = sig_b[LW-1:0];

    // Exponent zero covers both true zero and denormals (flushed).
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);
    assign inf_a  = (ea == '1) && (ma == '0);
    assign inf_b  = (eb == '1) && (mb == '0);
    assign nan_a  = (ea == '1) && (ma != '0);
    assign nan_b  = (eb == '1) && (mb != '0);

    logic            s1_sa, s1_sb;
    logic [EW-1:0]   s1_ea, s1_eb;
    logic [2*HW-1:0] s1_hh;
    logic [SW-1:0]   s1_hl, s1_lh;
    logic            s1_zero, s1_inf, s1_nan;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_sa   <= x1[EW+MW];
            s1_sb   <= x2[EW+MW];
            s1_ea   <= ea;
            s1_eb   <= eb;
            s1_hh   <= {{HW{1'b0}}, hi_a} * {{HW{1'b0}}, hi_b};
            s1_hl   <= {{LW{1'b0}}, hi_a} * {{HW{1'b0}}, lo_b};
            s1_lh   <= {{HW{1'b0}}, lo_a} * {{LW{1'b0}}, hi_b};
            s1_zero <= zero_a | zero_b;
            s1_inf  <= inf_a | inf_b;
            s1_nan  <= nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
            s1_tag  <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum partial products, exponent sum, sign
    // ------------------------------------------------------------------
    logic [PW-1:0]        cross_sum;
    logic [PW-1:0]        prod_sum;
    logic signed [XW-1:0] exp_sum;

    assign cross_sum = PW'(s1_hl) + PW'(s1_lh);
    assign prod_sum  = {s1_hh, {(2*LW){1'b0}}} + (cross_sum << LW);
    assign exp_sum   = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - $signed(XW'(BIAS));

    logic                 s2_sign;
    logic signed [XW-1:0] s2_exp;
    logic [PW-1:DROP]     s2_prod;
    logic                 s2_zero, s2_inf, s2_nan;
    logic [TAGW-1:0]      s2_tag;

    always_ff @(posedge clk) begin
        if (en) begin
            s2_sign <= s1_sa ^ s1_sb;
            s2_exp  <= exp_sum;
            s2_prod <= prod_sum[PW-1:DROP];
            s2_zero <= s1_zero;
            s2_inf  <= s1_inf;
            s2_nan  <= s1_nan;
            s2_tag  <= s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, classify
    // ------------------------------------------------------------------
    logic                 top;
    logic [MW-1:0]        mant, mant_fin;
    logic signed [XW-1:0] e_norm, e_fin;
    logic [EW+MW:0]       y_n;
    logic                 ovf_n, unf_n, nan_n;
`ifdef FMUL_PIPE_RNE_EN
    logic                 guard, sticky, round_up, carry;
`endif

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); the top bit
        // says whether it reached 2 and needs a one-place shift.
        top    = s2_prod[PW-1];
        mant   = top ? s2_prod[PW-2 -: MW] : s2_prod[PW-3 -: MW];
        e_norm = s2_exp + $signed({{(XW-1){1'b0}}, top});
`ifdef FMUL_PIPE_RNE_EN
        guard    = top ? s2_prod[PW-2-MW] : s2_prod[PW-3-MW];
        sticky   = top ? (|s2_prod[PW-3-MW:0]) : (|s2_prod[PW-4-MW:0]);
        round_up = guard & (sticky | mant[0]);
        // A carry out of the mantissa means the significand became 2.0:
        // the wrapped mantissa is already zero, only the exponent moves.
        {carry, mant_fin} = {1'b0, mant} + {{MW{1'b0}}, round_up};
        e_fin    = e_norm + $signed({{(XW-1){1'b0}}, carry});
`else
        mant_fin = mant;
        e_fin    = e_norm;
`endif
        y_n   = {s2_sign, e_fin[EW-1:0], mant_fin};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        nan_n = 1'b0;
        if (s2_nan) begin
            y_n   = QNAN;
            nan_n = 1'b1;
        end else if (s2_inf) begin
            y_n = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (s2_zero) begin
            y_n = {s2_sign, {(EW+MW){1'b0}}};
        end else if (e_fin >= EXP_MAX) begin
            y_n   = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
            ovf_n = 1'b1;
        end else if (e_fin <= EXP_ZERO) begin
            y_n   = {s2_sign, {(EW+MW){1'b0}}};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            y       <= '0;
            out_tag <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            nan     <= 1'b0;
        end else if (en) begin
            y       <= y_n;
            out_tag <= s2_tag;
            // Flags only ever assert alongside a real result.
            ovf     <= v2 & ovf_n;
            unf     <= v2 & unf_n;
            nan     <= v2 & nan_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe
// Purpose  : Self-checking bench for fmul_pipe (EW=8, MW=23, TAGW=5).
//            Directed vector table, latency, back-pressure, reset mid-stream
//            and randomised operands against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_pipe;

    typedef struct packed {
        logic [31:0] y;
        logic [4:0]  tag;
        logic        ovf;
        logic        unf;
        logic        nan;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
        logic        nan;
    } vec_t;

`ifdef FMUL_PIPE_RNE_EN
    localparam logic [31:0] TIE_Y = 32'h3FC00002;
`else
    localparam logic [31:0] TIE_Y = 32'h3FC00001;
`endif

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1, x2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [4:0]  out_tag;
    logic        ovf, unf, nan;

    int   checks = 0;
    int   errors = 0;
    int   seen   = 0;
    exp_t exp_q[$];
    bit   prod_done;

    fmul_pipe #(.EW(8), .MW(23), .TAGW(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag),
        .ovf       (ovf),
        .unf       (unf),
        .nan       (nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer significand product minus the lo*lo term
    // (12-bit low halves), then normalise / round / classify.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        exp_t            r;
        int              ea, eb, e, sh;
        longint unsigned fa, fb, p, q;
        logic            s, na, nb, ia, ib, za, zb;
        r     = '0;
        r.tag = tag;
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        s     = a[31] ^ b[31];
        za    = (ea == 0);
        zb    = (eb == 0);
        ia    = (ea == 255) && (a[22:0] == 23'h0);
        ib    = (eb == 255) && (b[22:0] == 23'h0);
        na    = (ea == 255) && (a[22:0] != 23'h0);
        nb    = (eb == 255) && (b[22:0] != 23'h0);
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.y   = 32'h7FC00000;
            r.nan = 1'b1;
        end else if (ia || ib) begin
            r.y = {s, 8'hFF, 23'h0};
        end else if (za || zb) begin
            r.y = {s, 31'h0};
        end else begin
            fa = 64'h800000 + 64'(a[22:0]);
            fb = 64'h800000 + 64'(b[22:0]);
            p  = fa * fb - (fa % 64'd4096) * (fb % 64'd4096);
            e  = ea + eb - 127;
            if (p >= 64'h8000_0000_0000) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            q = p >> sh;
`ifdef FMUL_PIPE_RNE_EN
            begin
                longint unsigned rem, half;
                rem  = p - (q << sh);
                half = 64'd1 << (sh - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                if (q == 64'h1000000) begin
                    q = 64'h800000;
                    e = e + 1;
                end
            end
`endif
            if (e >= 255) begin
                r.y   = {s, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.y   = {s, 31'h0};
                r.unf = 1'b1;
            end else begin
                r.y = {s, 8'(e), q[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: e = 8'h00;
            1: begin
                e = 8'hFF;
                if ($urandom_range(0, 1) == 0) r[22:0] = 23'h0;
            end
            2:       e = 8'($urandom_range(220, 254));
            3:       e = 8'($urandom_range(1, 40));
            default: e = 8'($urandom_range(100, 154));
        endcase
        r[30:23] = e;
        return r;
    endfunction

    function automatic exp_t mk(input logic [31:0] yv, input logic [4:0] t,
                                input logic o, input logic u, input logic n);
        exp_t r;
        r.y = yv; r.tag = t; r.ovf = o; r.unf = u; r.nan = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    // Present one operation from the next falling edge until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag, input exp_t e);
        int n;
        bit done;
        @(negedge clk);
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        in_tag = tag;
        n = 0;
        done = 0;
        while (!done) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(e);
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout in_ready got 0 required 1");
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic stop_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every transfer out is compared in order.
    initial begin
        exp_t got, e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && out_valid && out_ready) begin
                seen++;
                got = mk(y, out_tag, ovf, unf, nan);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got y=%h tag=%0d required no output", y, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL out_%0d got y=%h tag=%0d ovf=%b unf=%b nan=%b required y=%h tag=%0d ovf=%b unf=%b nan=%b",
                                 seen, got.y, got.tag, got.ovf, got.unf, got.nan,
                                 e.y, e.tag, e.ovf, e.unf, e.nan);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[17];
        logic [31:0] bp_a[6];
        logic [31:0] bp_b[6];
        logic [39:0] snap;
        int          seen0;

        vecs[0]  = '{"basic",      32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"ovf",        32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"unf",        32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{"neg_zero",   32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{"neg_inf",    32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"tie",        32'h3FC00000, 32'h3F800001, TIE_Y,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"one",        32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"nan_in",     32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"neg",        32'hBFC00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"zero_x_inf", 32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"denorm",     32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"max_norm",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"ovf_edge",   32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{"unf_edge",   32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{"min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{"neg_unf",    32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, 1'b0};

        bp_a = '{32'h3FC00000, 32'h40400000, 32'hC0000000, 32'h3F800001, 32'h41200000, 32'h7F000000};
        bp_b = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h3FC00000, 32'hC1200000, 32'h7F000000};

        rstn = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y",         64'(y),         64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_flags",     64'({ovf, unf, nan}), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rstn = 1'b1;

        // Latency: accepted in cycle 0, visible in cycle 3.
        send(32'h3FC00000, 32'h40000000, 5'd3, mk(32'h40400000, 5'd3, 1'b0, 1'b0, 1'b0));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("latency_c%0d", c), 64'(out_valid), (c == 3) ? 64'd1 : 64'd0);
        end
        drain("drain_latency");

        for (int i = 0; i < 17; i++)
            send(vecs[i].a, vecs[i].b, 5'(i),
                 mk(vecs[i].y, 5'(i), vecs[i].ovf, vecs[i].unf, vecs[i].nan));
        stop_in();
        drain("drain_table");

        // Back-pressure: out_ready low during cycles 4..7 of the stream.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(bp_a[i], bp_b[i], 5'(10 + i), model(bp_a[i], bp_b[i], 5'(10 + i)));
                stop_in();
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (k >= 4 && k <= 7) begin
                        out_ready = 1'b0;
                        #1;
                        chk($sformatf("bp_in_ready_k%0d", k), 64'(in_ready), 64'd0);
                        chk($sformatf("bp_out_valid_k%0d", k), 64'(out_valid), 64'd1);
                        if (k > 4)
                            chk($sformatf("bp_stable_k%0d", k), 64'({y, out_tag, ovf, unf, nan}), 64'(snap));
                        snap = {y, out_tag, ovf, unf, nan};
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_backpressure");

        // Randomised operands with random consumer stalls.
        prod_done = 0;
        fork
            begin
                logic [31:0] a, b;
                logic [4:0]  t;
                for (int i = 0; i < 150; i++) begin
                    a = rand_op();
                    b = rand_op();
                    t = 5'($urandom());
                    send(a, b, t, model(a, b, t));
                end
                stop_in();
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        // Reset with three operations in flight: none may come out.
        send(32'h3F800000, 32'h40000000, 5'd21, mk(32'h40000000, 5'd21, 1'b0, 1'b0, 1'b0));
        send(32'h40000000, 32'h40000000, 5'd22, mk(32'h40800000, 5'd22, 1'b0, 1'b0, 1'b0));
        send(32'h40400000, 32'h40000000, 5'd23, mk(32'h40C00000, 5'd23, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rstn = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        seen0 = seen;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset_mid_out_valid", 64'(out_valid), 64'd0);
        repeat (10) @(negedge clk);
        chk("reset_mid_no_output", 64'(seen - seen0), 64'd0);

        // Pipeline works again after the reset.
        send(32'h3FC00000, 32'h40000000, 5'd7, mk(32'h40400000, 5'd7, 1'b0, 1'b0, 1'b0));
        stop_in();
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
Parametrised pipelined floating-point multiplier. It generalises the existing fixed two-stage binary32 multiplier with configurable exponent/mantissa widths, a valid/ready handshake with back-pressure, and a tag field carried alongside each operation. It adds NaN handling, separate overflow/underflow flags, and optional round-to-nearest-even. It sits between the FPU issue logic and the writeback arbiter.

Parameters:
EW, 8, exponent width (bias = 2^(EW-1)-1)
MW, 23, stored mantissa width (hidden bit implicit)
TAGW, 5, width of the opaque tag carried with each operation

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
in_valid  in  1  operands present
in_ready  out  1  stage 1 can accept this cycle
x1  in  1+EW+MW  operand A {s,e,m}
x2  in  1+EW+MW  operand B
in_tag  in  TAGW  tag, returned unchanged with the result
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
y  out  1+EW+MW  product
out_tag  out  TAGW  tag of this result
ovf  out  1  result overflowed to infinity (finite inputs)
unf  out  1  result underflowed to zero (nonzero finite inputs)
nan  out  1  result is NaN

Behaviour:
- Clock and reset: clk rising edge; rstn synchronous, active-low. On reset all stage valid bits clear and out_valid=0. y, out_tag, ovf, unf and nan reset to 0. Data registers need not reset.
- Pipeline: 3 register stages. Global enable en = ~out_valid | out_ready, and in_ready = en.
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - When en=0 every stage holds, including bubbles. No data is lost or duplicated.
- Latency: exactly 3 cycles from accepted input to out_valid when there is no stall. Throughput is 1 per cycle.
- Stage 1 (split):
  - Decode sign, exponent and mantissa.
  - Split the significand {1,m} into high and low halves; form hi*hi, hi*lo and lo*hi.
  - Compute the classification bits zero, inf and nan.
- Stage 2 (sum):
  - Add the partial products; lo*lo is omitted.
  - Exponent sum e = e1+e2-bias, computed EW+2 bits wide and signed.
  - Sign = s1^s2.
- Stage 3 (normalise and round):
  - If the product is ≥2, shift right 1 and e+1.
  - Without rounding, truncate to MW bits. With rounding, see Optional Feature.
  - A rounding carry-out renormalises the significand and increments e.
- Classification (inputs with exp=0 are zero; denormals flush to zero):
  - Either input NaN (exp all ones, m≠0), or inf*0: y={0,all ones,1,0…} (canonical qNaN), nan=1.
  - Either input inf: y={s,all ones,0}.
  - Either input zero: y={s,0,0}. No flags.
  - Final e ≥ 2^EW-1: y={s,all ones,0}, ovf=1.
  - Final e ≤ 0: y={s,0,0}, unf=1.
  - Otherwise y={s,e[EW-1:0],m}.
- Flags: ovf, unf and nan are valid only with out_valid and are mutually exclusive.
- Back-pressure: while out_valid=1 and out_ready=0, y, out_tag and the flags are stable.
- Reset mid-operation: all in-flight results are discarded. No out_valid is produced for them after reset.

Optional Feature:
- Macro FMUL_PIPE_RNE_EN.
- Defined: round to nearest, ties to even.
  - Guard bit = first bit below the LSB; sticky = OR of the remaining kept product bits.
  - Round up if guard & (sticky | lsb).
- Undefined: truncation. No guard/sticky logic is synthesised.
- Classification, latency and handshake are identical in both builds.

Test Plan:
- Basic product: x1=0x3FC00000 (1.5), x2=0x40000000 (2.0), tag=3 → 3 cycles later y=0x40400000, out_tag=3, all flags 0.
- Overflow and underflow:
  - 0x7F000000 * 0x7F000000 → y=0x7F800000, ovf=1.
  - 0x00800000 * 0x00800000 → y=0x00000000, unf=1.
  - 0x80000000 * 0x3F800000 → y=0x80000000, no flags.
- Specials:
  - 0x7F800000 * 0x00000000 → y=0x7FC00000, nan=1.
  - 0xFF800000 * 0x40000000 → y=0xFF800000, no flags.
- Rounding tie: 0x3FC00000 * 0x3F800001 → y=0x3FC00001 without FMUL_PIPE_RNE_EN, 0x3FC00002 with it.
- Back-pressure: stream 6 back-to-back products with out_ready low for cycles 4-7 → in_ready low while stalled, all 6 results emerge in order with correct tags, outputs stable during the stall, no drops or duplicates.
- Reset mid-stream: assert rstn=0 for 1 cycle with 3 operations in flight → out_valid=0 the cycle after reset, and none of the 3 results ever appear.
